// File: rtl/switchbox_config_loader.sv
// Switch-box config loader: receives a word-streamed, XOR-checksummed frame into a shadow
// register and commits it atomically to config_out. Readback option: SWITCHBOX_CONFIG_LOADER_READBACK_EN.
//
// state      | meaning
// S_IDLE     | waiting for start (or rb_req when readback is built)
// S_LOAD     | accepting NUM_WORDS data words into the shadow register
// S_CHECK    | accepting the checksum word; commit on match, flag error otherwise
// S_READBACK | streaming config_out words plus their checksum (option only)
module switchbox_config_loader #(
  parameter int CONFIG_WIDTH = 112,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
  ,
  input  logic                    rb_req,
  output logic [WORD_WIDTH-1:0]   rb_word,
  output logic                    rb_valid,
  input  logic                    rb_ready
`endif
);

  localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    ,
    S_READBACK
`endif
  } state_t;

  state_t                state, state_next;
  logic [SHADOW_W-1:0]   shadow;
  logic [CNT_W-1:0]      counter;
  logic [WORD_WIDTH-1:0] checksum;
  logic                  clear_frame, take_word, commit, flag_error;

`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
  localparam logic [CNT_W-1:0] SUM_IDX = CNT_W'(NUM_WORDS);
  logic                  rb_step;
  logic [SHADOW_W-1:0]   config_pad;
  logic [WORD_WIDTH-1:0] rb_mux;

  // Last word is zero-padded above CONFIG_WIDTH; index NUM_WORDS selects the running checksum.
  assign config_pad = SHADOW_W'(config_out);

  always_comb begin
    rb_mux = checksum;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (counter == CNT_W'(i)) rb_mux = config_pad[i*WORD_WIDTH +: WORD_WIDTH];
    end
    rb_valid = (state == S_READBACK);
    rb_word  = (state == S_READBACK) ? rb_mux : '0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    word_ready  = 1'b0;
    busy        = 1'b0;
    clear_frame = 1'b0;
    take_word   = 1'b0;
    commit      = 1'b0;
    flag_error  = 1'b0;
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
    rb_step     = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          clear_frame = 1'b1;
          state_next  = S_LOAD;
        end
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
        else if (rb_req) begin
          clear_frame = 1'b1;
          state_next  = S_READBACK;
        end
`endif
      end
      S_LOAD: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (start) begin
          clear_frame = 1'b1;
        end else if (word_valid) begin
          take_word = 1'b1;
          if (counter == LAST_IDX) state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        word_ready = 1'b1;
        busy       = 1'b1;
        if (start) begin
          clear_frame = 1'b1;
          state_next  = S_LOAD;
        end else if (word_valid) begin
          if (word_in == checksum) commit     = 1'b1;
          else                     flag_error = 1'b1;
          state_next = S_IDLE;
        end
      end
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
      S_READBACK: begin
        busy = 1'b1;
        if (start) begin
          clear_frame = 1'b1;
          state_next  = S_LOAD;
        end else if (rb_ready) begin
          rb_step = 1'b1;
          if (counter == SUM_IDX) state_next = S_IDLE;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow       <= '0;
      counter      <= '0;
      checksum     <= '0;
      config_out   <= '0;
      config_valid <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start)      error <= 1'b0;
      if (flag_error) error <= 1'b1;
      if (clear_frame) begin
        counter  <= '0;
        checksum <= '0;
      end
      if (take_word) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (counter == CNT_W'(i)) shadow[i*WORD_WIDTH +: WORD_WIDTH] <= word_in;
        end
        checksum <= checksum ^ word_in;
        counter  <= counter + 1'b1;
      end
      // Only full, checksum-verified frames ever reach config_out.
      if (commit) begin
        config_out   <= shadow[CONFIG_WIDTH-1:0];
        config_valid <= 1'b1;
        done         <= 1'b1;
      end
`ifdef SWITCHBOX_CONFIG_LOADER_READBACK_EN
      if (rb_step) begin
        checksum <= checksum ^ rb_word;
        counter  <= counter + 1'b1;
      end
`endif
    end
  end

endmodule
